pipe_run_ctrl: RTL
==================

# pipe_run_ctrl

Parametrised run/step controller for the pipelined MIPS core. It replaces the fixed power-on reset pulse and the `clk & run` clock gating with a synchronous clock-enable scheme. It sequences core reset, supports free-run, N-cycle step and halt-with-drain modes, and tracks per-stage valid bits so a halt retires everything in flight. It sits beside the oscillator at the top of the pipeline; every stage register is enabled by `clk_en` and held in reset by `core_reset`.

## Interface
- `NSTAGES`, default 5: pipeline depth tracked by `stage_valid` (≥1).
- `CNTW`, default 32: width of the step counter and the cycle counter.
- `RST_CYCLES`, default 2: cycles `core_reset` is held after `reset` deasserts (≥1).
- `AUTORUN`, default 1: 1 means enter RUN after reset sequencing; 0 means enter IDLE.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid` input, 1 bit: a command is presented.
- `cmd` input, 2 bits: 00 NOP, 01 RUN, 10 STEP, 11 HALT.
- `cmd_count` input, CNTW bits: number of cycles for STEP; 0 is treated as 1.
- `cmd_ready` output, 1 bit: a command is accepted at an edge where `cmd_valid & cmd_ready`.
- `halt_req` input, 1 bit: halt request from the core (e.g. break retire); sampled each edge.
- `core_reset` output, 1 bit: synchronous active-high reset to the pipeline stages.
- `clk_en` output, 1 bit: pipeline advance enable.
- `issue` output, 1 bit: fetch is allowed to inject a new instruction this cycle.
- `stage_valid` output, NSTAGES bits: bit i set means stage i holds a live instruction.
- `state` output, 3 bits: 0 RESET, 1 IDLE, 2 RUN, 3 STEP, 4 DRAIN.
- `cycles` output, CNTW bits: count of enabled cycles; wraps modulo 2^CNTW.

## Operation
- All outputs are Moore functions of registered state. There is no combinational path from any input to any output.
- Values while `reset`=0: state RESET, `core_reset`=1, `clk_en`=0, `issue`=0, `cmd_ready`=0, `stage_valid`=0, `cycles`=0, internal step and reset counters=0.
- **RESET** (`core_reset`=1, `clk_en`=0, `cmd_ready`=0): counts RST_CYCLES edges after `reset` rises, then moves to RUN (AUTORUN=1) or IDLE. Commands and `halt_req` are ignored.
- **IDLE** (`clk_en`=0, `issue`=0, `cmd_ready`=1):
  - RUN → RUN.
  - STEP → STEP, with remaining = max(`cmd_count`, 1).
  - HALT and NOP are accepted with no effect.
  - `halt_req` is ignored.
- **RUN** (`clk_en`=1, `issue`=1, `cmd_ready`=1): an accepted HALT or `halt_req`=1 → DRAIN. RUN, STEP and NOP are accepted and dropped.
- **STEP** (`clk_en`=1, `issue`=1, `cmd_ready`=1):
  - remaining decrements each edge.
  - At the edge where remaining=1 → IDLE. No drain; `stage_valid` freezes.
  - HALT or `halt_req` → DRAIN, with priority over step completion on the same edge.
- **DRAIN** (`clk_en`=1, `issue`=0, `cmd_ready`=0): → IDLE at the edge where the shifted valid vector is all zero.
- Valid pipeline: on each edge with `clk_en`=1, `stage_valid` <= {`stage_valid`[NSTAGES-2:0], `issue`}. For NSTAGES=1 this reduces to `stage_valid` <= `issue`. It holds when `clk_en`=0.
- `cycles` increments on each edge with `clk_en`=1.

## Timing
- A command accepted at edge k takes effect from cycle k+1; `halt_req` sampled at edge k has the same latency.
- A HALT arriving with a full pipeline gives exactly NSTAGES DRAIN cycles, then IDLE. An empty pipeline drains in 1 cycle.
- STEP N gives exactly N cycles with `clk_en`=1 (1 cycle if N=0), then IDLE.
- A HALT command and `halt_req` in the same cycle produce a single DRAIN entry.
- When `reset` falls in any state, all registers return to their reset values immediately without waiting for a clock edge.
- At the edge after `reset` rises, RESET counting starts and `core_reset` deasserts together with the state change.
- `cycles` wraps from 2^CNTW-1 to 0 without any flag.

## Test plan
- **Reset release, defaults:** `reset` rises → `core_reset`=1 for 2 cycles, then state=RUN and `clk_en`=1; `stage_valid` goes 00001, 00011, … 11111 over 5 cycles.
- **HALT in RUN with full pipeline:** `stage_valid`=11111 and HALT accepted → 5 DRAIN cycles with `issue`=0 and `stage_valid` 11110, 11100, 11000, 10000, 00000; then IDLE with `clk_en`=0. `cycles` has advanced by 5 during drain.
- **STEP from IDLE (AUTORUN=0):** STEP with count 3 → `clk_en` high for exactly 3 cycles, `cycles` +3, `stage_valid`=00111, back to IDLE. STEP with count 0 → exactly 1 enabled cycle.
- **Halt during STEP:** STEP 100, then `halt_req` pulse at step 10 → DRAIN followed by IDLE, `cycles`=10+drain length. HALT and `halt_req` on the same edge → a single DRAIN; a HALT on the final step edge → DRAIN, not IDLE.
- **Async reset mid-RUN:** `reset`=0 between edges → all outputs take their reset values immediately. Commands during RESET → `cmd_ready`=0 and no effect.
- **Counter wrap (CNTW=4):** 16 enabled cycles → `cycles` returns to 0. STEP with `cmd_count`=15 → 15 enabled cycles.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Run/step controller for the pipelined core: sequences core reset, gates pipeline
// advance via clk_en and tracks per-stage valid bits so a halt drains everything in flight.
module pipe_run_ctrl #(
  parameter int unsigned NSTAGES    = 5,
  parameter int unsigned CNTW       = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned AUTORUN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [CNTW-1:0]    cmd_count,
  output logic               cmd_ready,
  input  logic               halt_req,
  output logic               core_reset,
  output logic               clk_en,
  output logic               issue,
  output logic [NSTAGES-1:0] stage_valid,
  output logic [2:0]         state,
  output logic [CNTW-1:0]    cycles
);

  localparam int unsigned RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNTW-1:0]    rem_q, rem_d;
  logic [CNTW-1:0]    cycles_q, cycles_d;
  logic [NSTAGES-1:0] sv_q, sv_d;
  logic               core_reset_q, core_reset_d;
  logic               clk_en_q, clk_en_d;
  logic               issue_q, issue_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               accept_c;
  logic               halt_c;
  logic [NSTAGES-1:0] sv_shift_c;

  // Next-state, counters and next registered outputs
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    rem_d        = rem_q;
    accept_c     = cmd_valid & cmd_ready_q;
    halt_c       = halt_req | (accept_c & (cmd == CMD_HALT));
    sv_shift_c   = (sv_q << 1) | NSTAGES'(issue_q);

    unique case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = (AUTORUN != 0) ? ST_RUN : ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      ST_IDLE: begin
        if (accept_c && cmd == CMD_RUN) begin
          state_d = ST_RUN;
        end else if (accept_c && cmd == CMD_STEP) begin
          state_d = ST_STEP;
          rem_d   = (cmd_count == '0) ? CNTW'(1) : cmd_count;
        end
      end
      ST_RUN: begin
        if (halt_c) state_d = ST_DRAIN;
      end
      ST_STEP: begin
        rem_d = rem_q - CNTW'(1);
        // A halt outranks step completion on the same edge
        if (halt_c) begin
          state_d = ST_DRAIN;
        end else if (rem_q == CNTW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (sv_shift_c == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase

    core_reset_d = (state_d == ST_RESET);
    clk_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    issue_d      = (state_d == ST_RUN) || (state_d == ST_STEP);
    cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_STEP);
    sv_d         = clk_en_q ? sv_shift_c : sv_q;
    cycles_d     = clk_en_q ? cycles_q + CNTW'(1) : cycles_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      rem_q        <= '0;
      cycles_q     <= '0;
      sv_q         <= '0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      issue_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      rem_q        <= rem_d;
      cycles_q     <= cycles_d;
      sv_q         <= sv_d;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      issue_q      <= issue_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign state       = state_q;
  assign core_reset  = core_reset_q;
  assign clk_en      = clk_en_q;
  assign issue       = issue_q;
  assign cmd_ready   = cmd_ready_q;
  assign stage_valid = sv_q;
  assign cycles      = cycles_q;

endmodule
